id_fetch_rx: RTL and testbench

- Instruction-decode front end; the consumer of the 62-bit fetch bundle {PCP1[31:2], instr[31:0]} produced by the fetch stage.
- Detects load-use and branch-operand hazards, resolves j/jal/jr/beq/bne in ID, and drives the fetch-control signals back to fetch: PCWrite, IF_FLUSH, jpcAvail, JPC.
- Registers the accepted instruction into the ID/EX bundle.
- Instruction word 0 is a bubble/nop throughout.

---
 rtl/id_fetch_rx_if.sv | 23 ++
 rtl/id_fetch_rx.sv | 167 ++++++++++++++++
 tb/tb_id_fetch_rx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_fetch_rx_if.sv
// ID-stage bundle: fetch bundle and forwarded operands in, fetch control and ID/EX bundle out.
interface id_fetch_rx_if;
  logic [61:0] i_ID_DATA;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ext_stall;
  logic        PCWrite;
  logic        IF_FLUSH;
  logic        jpcAvail;
  logic [29:0] JPC;
  logic [61:0] o_EX_DATA;
  logic        o_stalling;

  modport master (
    output i_ID_DATA, rs_val, rt_val, ext_stall,
    input  PCWrite, IF_FLUSH, jpcAvail, JPC, o_EX_DATA, o_stalling
  );

  modport slave (
    input  i_ID_DATA, rs_val, rt_val, ext_stall,
    output PCWrite, IF_FLUSH, jpcAvail, JPC, o_EX_DATA, o_stalling
  );
endinterface

// File: rtl/id_fetch_rx.sv
// ID front end: hazard stall, branch/jump resolution, ID/EX register (1 cycle to o_EX_DATA).
// Backpressure: hazards hold fetch via PCWrite=0 and issue bubbles; ext_stall freezes everything.
module id_fetch_rx #(
  parameter int unsigned LOAD_USE_STALL    = 1,
  parameter int unsigned BRANCH_LOAD_STALL = 2,
  parameter int unsigned BRANCH_ALU_STALL  = 1
) (
  input  logic         clk,
  input  logic         rst,
  id_fetch_rx_if.slave bus
);

  typedef struct packed {
    logic [29:0] pcp1;
    logic [31:0] instr;
  } bundle_t;

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] LUS_N = 2'(LOAD_USE_STALL);
  localparam logic [1:0] BLS_N = 2'(BRANCH_LOAD_STALL);
  localparam logic [1:0] BAS_N = 2'(BRANCH_ALU_STALL);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [1:0]  n;
  bundle_t     id_b, ex_q, ex_nx;

  // ID-side decode
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic        id_rtype, id_jr, id_j, id_jal, id_beq, id_bne, id_ialu, id_lw, id_sw;
  logic        id_reads_rs, id_reads_rt, id_branch;

  // EX-side decode
  logic [5:0]  ex_op;
  logic        ex_rtype, ex_ialu, ex_lw, ex_jal;
  logic [4:0]  ex_dest;
  logic        hit;

  // redirect
  logic        operands_eq, taken;
  logic [29:0] br_tgt, tgt;
  logic        redirect, pc_write;

  assign id_b  = bus.i_ID_DATA;
  assign id_op = id_b.instr[31:26];
  assign id_rs = id_b.instr[25:21];
  assign id_rt = id_b.instr[20:16];

  assign id_rtype = (id_op == OP_RTYPE) && (id_b.instr != 32'd0);
  assign id_jr    = id_rtype && (id_b.instr[5:0] == FN_JR);
  assign id_j     = (id_op == OP_J);
  assign id_jal   = (id_op == OP_JAL);
  assign id_beq   = (id_op == OP_BEQ);
  assign id_bne   = (id_op == OP_BNE);
  assign id_ialu  = (id_op[5:3] == 3'b001);
  assign id_lw    = (id_op == OP_LW);
  assign id_sw    = (id_op == OP_SW);

  assign id_reads_rs = id_rtype || id_ialu || id_lw || id_sw || id_beq || id_bne;
  assign id_reads_rt = (id_rtype && !id_jr) || id_sw || id_beq || id_bne;
  assign id_branch   = id_beq || id_bne || id_jr;

  assign ex_op    = ex_q.instr[31:26];
  assign ex_rtype = (ex_op == OP_RTYPE) && (ex_q.instr != 32'd0);
  assign ex_ialu  = (ex_op[5:3] == 3'b001);
  assign ex_lw    = (ex_op == OP_LW);
  assign ex_jal   = (ex_op == OP_JAL);

  always_comb begin
    ex_dest = 5'd0;
    if (ex_rtype)
      ex_dest = ex_q.instr[15:11];
    else if (ex_ialu || ex_lw)
      ex_dest = ex_q.instr[20:16];
    else if (ex_jal)
      ex_dest = 5'd31;
  end

  // $0 is never a real producer, so it is filtered before the compare
  assign hit = (ex_dest != 5'd0) &&
               ((id_reads_rs && (id_rs == ex_dest)) || (id_reads_rt && (id_rt == ex_dest)));

  always_comb begin
    n = 2'd0;
    if (hit) begin
      if (id_branch)
        n = ex_lw ? BLS_N : BAS_N;
      else if (ex_lw)
        n = LUS_N;
    end
  end

  assign operands_eq = (bus.rs_val == bus.rt_val);
  assign taken       = id_j || id_jal || id_jr || (id_beq && operands_eq) || (id_bne && !operands_eq);
  assign br_tgt      = id_b.pcp1 + {{14{id_b.instr[15]}}, id_b.instr[15:0]};

  always_comb begin
    tgt = br_tgt;
    if (id_j || id_jal)
      tgt = {id_b.pcp1[29:26], id_b.instr[25:0]};
    else if (id_jr)
      tgt = bus.rs_val[31:2];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ex_nx    = ex_q;
    pc_write = 1'b0;
    redirect = 1'b0;
    if (!bus.ext_stall) begin
      case (state)
        RUN: begin
          if (n != 2'd0) begin
            ex_nx = '0;
            if (n > 2'd1) begin
              state_nx = STALL;
              cnt_nx   = n - 2'd1;
            end
          end else begin
            pc_write = 1'b1;
            ex_nx    = id_b;
            redirect = taken;
          end
        end
        STALL: begin
          ex_nx  = '0;
          cnt_nx = cnt - 2'd1;
          if (cnt <= 2'd1)
            state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
      ex_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ex_q  <= ex_nx;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IF_FLUSH   = redirect;
  assign bus.jpcAvail   = redirect;
  assign bus.JPC        = redirect ? tgt : id_b.pcp1;
  assign bus.o_EX_DATA  = ex_q;
  assign bus.o_stalling = (state == STALL) || ((state == RUN) && (n != 2'd0));

endmodule

// File: tb/tb_id_fetch_rx.sv
// Bench for id_fetch_rx: vector table for hazard/redirect cases plus hand sequences for ext_stall and reset.
module tb_id_fetch_rx;
  logic clk;
  logic rst;

  id_fetch_rx_if bus ();
  id_fetch_rx_if bus3 ();

  id_fetch_rx u_dut (.clk(clk), .rst(rst), .bus(bus));
  id_fetch_rx #(.BRANCH_ALU_STALL(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08, J = 6'h02, JAL = 6'h03;

  typedef struct {
    logic [31:0] setup;
    logic [31:0] id;
    logic [29:0] pcp1;
    logic [31:0] rs;
    logic [31:0] rt;
    int          nb;
    bit          red;
    logic [29:0] jpc;
  } vec_t;

  vec_t        vq[$];
  logic [61:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          nb3;
  bit          done3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] op, logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] s, input logic [31:0] id, input logic [29:0] p,
                      input logic [31:0] a, input logic [31:0] b, input int nb,
                      input bit red, input logic [29:0] jpc);
    vec_t v;
    v.setup = s; v.id = id; v.pcp1 = p; v.rs = a; v.rt = b; v.nb = nb; v.red = red; v.jpc = jpc;
    vq.push_back(v);
  endtask

  // Inputs already driven; check combinational outputs mid-cycle, then the registered bundle after the edge.
  task automatic cyc(input string nm, input bit e_pcw, input bit e_red, input logic [29:0] e_jpc,
                     input bit e_stl, input logic [61:0] e_ex);
    logic [61:0] exp_ex;
    #4;
    check({nm, "_pcw"}, bus.PCWrite, e_pcw);
    check({nm, "_flush"}, bus.IF_FLUSH, e_red);
    check({nm, "_avail"}, bus.jpcAvail, e_red);
    if (e_red) check({nm, "_jpc"}, bus.JPC, e_jpc);
    check({nm, "_stl"}, bus.o_stalling, e_stl);
    sb.push_back(e_ex);
    @(posedge clk);
    #1;
    exp_ex = sb.pop_front();
    check({nm, "_ex"}, bus.o_EX_DATA, exp_ex);
  endtask

  task automatic drive(input logic [61:0] d, input logic [31:0] a, input logic [31:0] b, input bit xs);
    bus.i_ID_DATA = d;
    bus.rs_val    = a;
    bus.rt_val    = b;
    bus.ext_stall = xs;
  endtask

  initial begin
    rst = 1'b0;
    drive('0, '0, '0, 1'b0);
    bus3.i_ID_DATA = '0; bus3.rs_val = '0; bus3.rt_val = '0; bus3.ext_stall = 1'b0;

    addv(itype(LW, 1, 2, 0),    rtype(2, 4, 3, 6'h20),     30'h10, 0, 0, 1, 0, 0);
    addv(itype(LW, 1, 4, 0),    rtype(2, 4, 3, 6'h20),     30'h10, 0, 0, 1, 0, 0);
    addv(itype(LW, 1, 5, 0),    itype(BEQ, 5, 6, 16'd4),   30'h100, 7, 7, 2, 1, 30'h104);
    addv(itype(LW, 1, 5, 0),    itype(BNE, 5, 6, 16'd4),   30'h100, 7, 7, 2, 0, 0);
    addv(itype(ADDI, 0, 7, 1),  itype(BNE, 7, 0, 16'hFFFE), 30'h40, 5, 0, 1, 1, 30'h3E);
    addv(itype(ADDI, 0, 7, 1),  rtype(7, 7, 8, 6'h20),     30'h10, 0, 0, 0, 0, 0);
    addv(itype(LW, 1, 0, 0),    rtype(0, 0, 3, 6'h20),     30'h10, 0, 0, 0, 0, 0);
    addv(itype(LW, 1, 0, 0),    itype(BEQ, 0, 0, 16'd4),   30'h100, 3, 3, 0, 1, 30'h104);
    addv(32'd0,                 jtype(J, 26'h0000123),     30'h3000_0010, 0, 0, 0, 1, 30'h3000_0123);
    addv(rtype(1, 1, 31, 6'h20), rtype(31, 0, 0, 6'h08),   30'h20, 32'h408, 0, 1, 1, 30'h102);
    addv(itype(LW, 1, 31, 0),   rtype(31, 0, 0, 6'h08),    30'h20, 32'h408, 0, 2, 1, 30'h102);
    addv(itype(LW, 1, 3, 0),    rtype(4, 3, 0, 6'h08),     30'h20, 32'h408, 0, 0, 1, 30'h102);
    addv(32'd0,                 jtype(JAL, 26'h0ABCDEF),   30'h100, 0, 0, 0, 1, 30'h00AB_CDEF);
    addv(32'd0,                 itype(BEQ, 1, 2, 16'd8),   30'h80, 1, 2, 0, 0, 0);
    addv(32'd0,                 itype(BNE, 1, 2, 16'hFFFE), 30'h1, 1, 2, 0, 1, 30'h3FFF_FFFF);
    addv(itype(LW, 1, 9, 0),    itype(SW, 10, 9, 16'd0),   30'h10, 0, 0, 1, 0, 0);
    addv(itype(LW, 1, 6, 0),    itype(ADDI, 6, 7, 16'd1),  30'h10, 0, 0, 1, 0, 0);
    addv(itype(LW, 1, 6, 0),    itype(ADDI, 1, 6, 16'd1),  30'h10, 0, 0, 0, 0, 0);
    addv(itype(ADDI, 0, 7, 1),  itype(LW, 7, 8, 16'd0),    30'h10, 0, 0, 0, 0, 0);

    #2;
    check("rst_ex", bus.o_EX_DATA, 62'd0);
    check("rst_pcw", bus.PCWrite, 1'b1);
    check("rst_flush", bus.IF_FLUSH, 1'b0);
    check("rst_avail", bus.jpcAvail, 1'b0);
    check("rst_stl", bus.o_stalling, 1'b0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      drive('0, '0, '0, 1'b0);
      cyc($sformatf("v%0d_nop", i), 1, 0, 0, 0, '0);
      drive({30'h10, vq[i].setup}, '0, '0, 1'b0);
      cyc($sformatf("v%0d_setup", i), 1, 0, 0, 0, {30'h10, vq[i].setup});
      drive({vq[i].pcp1, vq[i].id}, vq[i].rs, vq[i].rt, 1'b0);
      for (int b = 0; b < vq[i].nb; b++)
        cyc($sformatf("v%0d_bub%0d", i, b), 0, 0, 0, 1, '0);
      cyc($sformatf("v%0d_issue", i), 1, vq[i].red, vq[i].jpc, 0, {vq[i].pcp1, vq[i].id});
    end

    // ext_stall over an issuing jump: no redirect, EX holds the addi
    drive('0, '0, '0, 1'b0);
    cyc("xj_nop", 1, 0, 0, 0, '0);
    drive({30'h10, itype(ADDI, 0, 7, 1)}, '0, '0, 1'b0);
    cyc("xj_setup", 1, 0, 0, 0, {30'h10, itype(ADDI, 0, 7, 1)});
    drive({30'h3000_0010, jtype(J, 26'h0000123)}, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("xj_hold%0d", k), 0, 0, 0, 0, {30'h10, itype(ADDI, 0, 7, 1)});
    bus.ext_stall = 1'b0;
    cyc("xj_issue", 1, 1, 30'h3000_0123, 0, {30'h3000_0010, jtype(J, 26'h0000123)});

    // ext_stall before and inside a 2-bubble load/branch stall
    drive('0, '0, '0, 1'b0);
    cyc("xs_nop", 1, 0, 0, 0, '0);
    drive({30'h10, itype(LW, 1, 5, 0)}, '0, '0, 1'b0);
    cyc("xs_setup", 1, 0, 0, 0, {30'h10, itype(LW, 1, 5, 0)});
    drive({30'h100, itype(BEQ, 5, 6, 16'd4)}, 7, 7, 1'b1);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("xs_run%0d", k), 0, 0, 0, 1, {30'h10, itype(LW, 1, 5, 0)});
    bus.ext_stall = 1'b0;
    cyc("xs_bub0", 0, 0, 0, 1, '0);
    bus.ext_stall = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("xs_frz%0d", k), 0, 0, 0, 1, '0);
    bus.ext_stall = 1'b0;
    cyc("xs_bub1", 0, 0, 0, 1, '0);
    cyc("xs_issue", 1, 1, 30'h104, 0, {30'h100, itype(BEQ, 5, 6, 16'd4)});

    // reset asserted in STALL with one bubble left
    drive('0, '0, '0, 1'b0);
    cyc("rs_nop", 1, 0, 0, 0, '0);
    drive({30'h10, itype(LW, 1, 5, 0)}, '0, '0, 1'b0);
    cyc("rs_setup", 1, 0, 0, 0, {30'h10, itype(LW, 1, 5, 0)});
    drive({30'h100, itype(BEQ, 5, 6, 16'd4)}, 7, 7, 1'b0);
    cyc("rs_bub0", 0, 0, 0, 1, '0);
    rst = 1'b0;
    #1;
    check("rs_mid_ex", bus.o_EX_DATA, 62'd0);
    check("rs_mid_pcw", bus.PCWrite, 1'b1);
    check("rs_mid_stl", bus.o_stalling, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    drive({30'h10, itype(LW, 1, 2, 0)}, '0, '0, 1'b0);
    cyc("rs_lw", 1, 0, 0, 0, {30'h10, itype(LW, 1, 2, 0)});
    drive({30'h11, rtype(2, 4, 3, 6'h20)}, '0, '0, 1'b0);
    cyc("rs_use_bub", 0, 0, 0, 1, '0);
    cyc("rs_use_issue", 1, 0, 0, 0, {30'h11, rtype(2, 4, 3, 6'h20)});

    // BRANCH_ALU_STALL=3 instance, ext_stall while two bubbles remain
    bus3.i_ID_DATA = '0;
    @(posedge clk); #1;
    bus3.i_ID_DATA = {30'h10, itype(ADDI, 0, 7, 1)};
    @(posedge clk); #1;
    check("d3_setup_ex", bus3.o_EX_DATA, {30'h10, itype(ADDI, 0, 7, 1)});
    bus3.i_ID_DATA = {30'h40, itype(BNE, 7, 0, 16'hFFFE)};
    bus3.rs_val = 32'd5;
    bus3.rt_val = 32'd0;
    #4;
    check("d3_first_pcw", bus3.PCWrite, 1'b0);
    check("d3_first_stl", bus3.o_stalling, 1'b1);
    @(posedge clk); #1;
    check("d3_first_ex", bus3.o_EX_DATA, 62'd0);
    bus3.ext_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      check($sformatf("d3_frz%0d_pcw", k), bus3.PCWrite, 1'b0);
      check($sformatf("d3_frz%0d_avail", k), bus3.jpcAvail, 1'b0);
      check($sformatf("d3_frz%0d_stl", k), bus3.o_stalling, 1'b1);
      @(posedge clk); #1;
    end
    bus3.ext_stall = 1'b0;
    nb3 = 0;
    done3 = 1'b0;
    for (int k = 0; k < 8 && !done3; k++) begin
      #4;
      if (bus3.PCWrite) begin
        done3 = 1'b1;
        check("d3_avail", bus3.jpcAvail, 1'b1);
        check("d3_jpc", bus3.JPC, 30'h3E);
      end else begin
        nb3++;
      end
      @(posedge clk); #1;
    end
    check("d3_issued", done3, 1'b1);
    check("d3_bubbles", nb3, 2);
    check("d3_issue_ex", bus3.o_EX_DATA, {30'h40, itype(BNE, 7, 0, 16'hFFFE)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
